ctrl_lgc: RTL and testbench

- Control-logic block of the 8259A-compatible PIC.
- Decodes the ICW1–ICW4 initialization sequence and OCW2 EOI commands from the internal data bus.
- Raises INT toward the CPU when the priority resolver reports a winning request.
- Runs the two-pulse INTA sequence: drives the vector onto D and produces EOI/AEOI pulses.
- Sits between the read/write logic, priority resolver, IRR/ISR/IMR registers and the cascade comparator.

---
 rtl/ctrl_lgc_pkg.sv | 39 +++
 rtl/ctrl_lgc_if.sv | 21 ++
 rtl/ctrl_lgc_init_fsm.sv | 107 ++++++++++
 rtl/ctrl_lgc.sv | 121 ++++++++++++
 tb/tb_ctrl_lgc.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_lgc_pkg.sv
// Shared constants for the 8259A control logic: init FSM state codes,
// read-select codes, ICW/OCW bit positions and the vector-drive rule.
package ctrl_lgc_pkg;

    localparam logic [2:0] ST_UNINIT = 3'd0;
    localparam logic [2:0] ST_ICW2   = 3'd1;
    localparam logic [2:0] ST_ICW3   = 3'd2;
    localparam logic [2:0] ST_ICW4   = 3'd3;
    localparam logic [2:0] ST_READY  = 3'd4;

    localparam logic [2:0] RD_IRR = 3'd0;
    localparam logic [2:0] RD_ISR = 3'd1;
    localparam logic [2:0] RD_IMR = 3'd2;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;
    localparam int CMD_SEL   = 4;
    localparam int OCW_SEL   = 3;
    localparam int OCW2_EOI  = 5;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_BUF  = 3;

    // Whether this device owns the vector on the second INTA pulse.
    function automatic logic vec_drive(
        input logic       sngl,
        input logic       s,
        input logic       cl,
        input logic [7:0] icw3,
        input logic [2:0] y
    );
        logic r;
        if (sngl)   r = 1'b1;
        else if (s) r = ~icw3[y];
        else        r = cl;
        return r;
    endfunction

endpackage

// File: rtl/ctrl_lgc_if.sv
// CPU-side bus of the control logic: address, write/read strobes,
// read select, INTA, and the int / D-drive-enable results.
interface ctrl_lgc_if;
    logic       a0;
    logic       wrflg;
    logic       rdflag;
    logic [2:0] rwadr;
    logic       inta;
    logic       int_o;
    logic       en;

    modport master (
        output a0, wrflg, rdflag, rwadr, inta,
        input  int_o, en
    );

    modport slave (
        input  a0, wrflg, rdflag, rwadr, inta,
        output int_o, en
    );
endinterface

// File: rtl/ctrl_lgc_init_fsm.sv
// ICW1..ICW4 sequencing and mode bits. Ports: clk/reset, write strobe,
// a0, data byte in; ICW1/EOI command strobes, ino and latched mode fields.
module ctrl_lgc_init_fsm
    import ctrl_lgc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_i,
    input  logic       a0_i,
    input  logic [7:0] din_i,
    output logic       icw1_o,
    output logic       eoi_cmd_o,
    output logic       ino_o,
    output logic       ltim_o,
    output logic       sngl_o,
    output logic       buff_o,
    output logic       ar_o,
    output logic [4:0] tbase_o,
    output logic [7:0] icw3_o
);

    logic [2:0] state_q, state_d;
    logic       ltim_q, ltim_d;
    logic       sngl_q, sngl_d;
    logic       ic4_q, ic4_d;
    logic       buff_q, buff_d;
    logic       ar_q, ar_d;
    logic [4:0] tbase_q, tbase_d;
    logic [7:0] icw3_q, icw3_d;
    logic       rdy;

    assign rdy    = (state_q == ST_READY);
    assign icw1_o = wr_i && !a0_i && din_i[CMD_SEL];

    assign eoi_cmd_o = wr_i && !a0_i && rdy
                    && !din_i[CMD_SEL] && !din_i[OCW_SEL]
                    && din_i[OCW2_EOI];

    always_comb begin
        state_d = state_q;
        ltim_d  = ltim_q;
        sngl_d  = sngl_q;
        ic4_d   = ic4_q;
        buff_d  = buff_q;
        ar_d    = ar_q;
        tbase_d = tbase_q;
        icw3_d  = icw3_q;
        if (icw1_o) begin
            ltim_d  = din_i[ICW1_LTIM];
            sngl_d  = din_i[ICW1_SNGL];
            ic4_d   = din_i[ICW1_IC4];
            buff_d  = 1'b0;
            ar_d    = 1'b0;
            state_d = ST_ICW2;
        end else if (wr_i && a0_i) begin
            unique case (state_q)
                ST_ICW2: begin
                    tbase_d = din_i[7:3];
                    if (!sngl_q)    state_d = ST_ICW3;
                    else if (ic4_q) state_d = ST_ICW4;
                    else            state_d = ST_READY;
                end
                ST_ICW3: begin
                    icw3_d  = din_i;
                    state_d = ic4_q ? ST_ICW4 : ST_READY;
                end
                ST_ICW4: begin
                    buff_d  = din_i[ICW4_BUF];
                    ar_d    = din_i[ICW4_AEOI];
                    state_d = ST_READY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_UNINIT;
            ltim_q  <= 1'b0;
            sngl_q  <= 1'b0;
            ic4_q   <= 1'b0;
            buff_q  <= 1'b0;
            ar_q    <= 1'b0;
            tbase_q <= 5'd0;
            icw3_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ltim_q  <= ltim_d;
            sngl_q  <= sngl_d;
            ic4_q   <= ic4_d;
            buff_q  <= buff_d;
            ar_q    <= ar_d;
            tbase_q <= tbase_d;
            icw3_q  <= icw3_d;
        end
    end

    assign ino_o   = rdy;
    assign ltim_o  = ltim_q;
    assign sngl_o  = sngl_q;
    assign buff_o  = buff_q;
    assign ar_o    = ar_q;
    assign tbase_o = tbase_q;
    assign icw3_o  = icw3_q;

endmodule

// File: rtl/ctrl_lgc.sv
// 8259A control logic top: INT generation, INTA sequencing, EOI pulse and
// D-bus mux. Ports: clk/reset, CPU bus interface, D, resolver and register inputs, mode outputs.
module ctrl_lgc
    import ctrl_lgc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    ctrl_lgc_if.slave  bus,
    inout  wire  [7:0] D,
    input  logic [7:0] R,
    input  logic [2:0] Y,
    input  logic       isprior,
    input  logic       S,
    input  logic       CLsig,
    input  logic [7:0] Mask,
    input  logic [7:0] isr,
    input  logic [7:0] irr,
    output logic       ino,
    output logic       buff,
    output logic       LTIM,
    output logic       eoi,
    output logic       ar
);

    logic       icw1, eoi_cmd, sngl;
    logic [4:0] tbase;
    logic [7:0] icw3;

    ctrl_lgc_init_fsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .wr_i      (bus.wrflg),
        .a0_i      (bus.a0),
        .din_i     (D),
        .icw1_o    (icw1),
        .eoi_cmd_o (eoi_cmd),
        .ino_o     (ino),
        .ltim_o    (LTIM),
        .sngl_o    (sngl),
        .buff_o    (buff),
        .ar_o      (ar),
        .tbase_o   (tbase),
        .icw3_o    (icw3)
    );

    logic       inta_q;
    logic [1:0] cnt_q, cnt_d, cnt_b;
    logic       int_q, int_d;
    logic       vec_q, vec_d;
    logic       eoi_q, eoi_d;
    logic       rise, fall;

    assign rise = bus.inta && !inta_q;
    assign fall = !bus.inta && inta_q;

    // ICW1 restarts the count, but an INTA edge in the same cycle still counts.
    assign cnt_b = icw1 ? 2'd0 : cnt_q;

    always_comb begin
        int_d = int_q;
        cnt_d = cnt_b;
        vec_d = icw1 ? 1'b0 : vec_q;
        eoi_d = eoi_cmd;
        if (icw1) int_d = 1'b0;
        else if (ino && isprior && (|R)) int_d = 1'b1;
        if (fall && cnt_b == 2'd2) begin
            cnt_d = 2'd0;
            vec_d = 1'b0;
            if (ar) eoi_d = 1'b1;
        end
        if (rise) begin
            if (cnt_b == 2'd0) begin
                cnt_d = 2'd1;
                int_d = 1'b0;
            end else if (cnt_b == 2'd1) begin
                cnt_d = 2'd2;
                vec_d = vec_drive(sngl, S, CLsig, icw3, Y);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inta_q <= 1'b0;
            cnt_q  <= 2'd0;
            int_q  <= 1'b0;
            vec_q  <= 1'b0;
            eoi_q  <= 1'b0;
        end else begin
            inta_q <= bus.inta;
            cnt_q  <= cnt_d;
            int_q  <= int_d;
            vec_q  <= vec_d;
            eoi_q  <= eoi_d;
        end
    end

    logic [7:0] rd_data, dout;
    logic       vec_en, rd_en, en;

    always_comb begin
        unique case (bus.rwadr)
            RD_IRR:  rd_data = irr;
            RD_ISR:  rd_data = isr;
            RD_IMR:  rd_data = Mask;
            default: rd_data = 8'h00;
        endcase
    end

    // Vector drive ends combinationally with inta so D is released at once.
    assign vec_en = vec_q && bus.inta;
    assign rd_en  = bus.rdflag && !bus.inta;
    assign en     = vec_en || rd_en;
    assign dout   = vec_en ? {tbase, Y} : rd_data;
    assign D      = en ? dout : 8'hzz;

    assign bus.en    = en;
    assign bus.int_o = int_q;
    assign eoi       = eoi_q;

endmodule

// File: tb/tb_ctrl_lgc.sv
// Self-checking bench for ctrl_lgc: vector table, directed INTA/read
// sequences and randomized traffic against a queue-based model.
module tb_ctrl_lgc;

    logic       clk, reset;
    logic [7:0] R, Mask, isr, irr;
    logic [2:0] Y;
    logic       isprior, S, CLsig;
    logic       ino, buff, LTIM, eoi, ar;
    logic       tb_oe;
    logic [7:0] tb_dat;
    wire  [7:0] D;

    ctrl_lgc_if bus();

    assign D = tb_oe ? tb_dat : 8'hzz;

    ctrl_lgc dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .D       (D),
        .R       (R),
        .Y       (Y),
        .isprior (isprior),
        .S       (S),
        .CLsig   (CLsig),
        .Mask    (Mask),
        .isr     (isr),
        .irr     (irr),
        .ino     (ino),
        .buff    (buff),
        .LTIM    (LTIM),
        .eoi     (eoi),
        .ar      (ar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: remaining init words are a queue of ICW numbers.
    bit         m_init, m_ltim, m_sngl, m_buff, m_ar, m_eoi;
    logic [7:0] m_base, m_icw3;
    int         m_need[$];

    function automatic bit m_ready();
        return m_init && m_need.size() == 0;
    endfunction

    task automatic model_wr(input logic a0, input logic [7:0] d);
        int k;
        m_eoi = m_ready() && !a0 && d[4:3] == 2'b00 && d[5];
        if (!a0 && d[4]) begin
            m_init = 1;
            m_ltim = d[3];
            m_sngl = d[1];
            m_buff = 0;
            m_ar   = 0;
            m_need.delete();
            m_need.push_back(2);
            if (!d[1]) m_need.push_back(3);
            if (d[0])  m_need.push_back(4);
        end else if (a0 && m_need.size() > 0) begin
            k = m_need.pop_front();
            if (k == 2) m_base = d & 8'hF8;
            if (k == 3) m_icw3 = d;
            if (k == 4) begin
                m_buff = d[3];
                m_ar   = d[1];
            end
        end
    endtask

    task automatic wr(input logic a0, input logic [7:0] d);
        bus.a0 = a0;
        tb_oe = 1'b1;
        tb_dat = d;
        bus.wrflg = 1'b1;
        tick();
        bus.wrflg = 1'b0;
        tb_oe = 1'b0;
        model_wr(a0, d);
    endtask

    task automatic check_modes(input string tag);
        chk({tag, " ino"}, ino, m_ready());
        chk({tag, " ltim"}, LTIM, m_ltim);
        chk({tag, " buff"}, buff, m_buff);
        chk({tag, " ar"}, ar, m_ar);
        chk({tag, " eoi"}, eoi, m_eoi);
        chk({tag, " int"}, bus.int_o, 1'b0);
    endtask

    task automatic inta_seq(input string tag, input bit drv,
                            input logic [7:0] vec, input bit exp_eoi);
        bus.inta = 1'b1;
        tick();
        chk({tag, " p1 int"}, bus.int_o, 1'b0);
        chk({tag, " p1 en"}, bus.en, 1'b0);
        bus.inta = 1'b0;
        tick();
        bus.inta = 1'b1;
        tick();
        chk({tag, " p2 en"}, bus.en, drv);
        if (drv) chk({tag, " p2 vec"}, D, vec);
        bus.inta = 1'b0;
        #1;
        chk({tag, " release en"}, bus.en, 1'b0);
        tick();
        chk({tag, " aeoi"}, eoi, exp_eoi);
        tick();
        chk({tag, " aeoi end"}, eoi, 1'b0);
    endtask

    typedef struct {
        bit       a0;
        bit [7:0] d;
        bit [4:0] exp;
    } vec_t;

    function automatic vec_t row(input bit a0, input bit [7:0] d,
                                 input bit [4:0] exp);
        vec_t v;
        v.a0 = a0;
        v.d = d;
        v.exp = exp;
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        logic [7:0] d, ev;
        logic [2:0] y, ra;
        bit         drv;
        int         op;

        // exp = {ino, ltim, buff, ar, eoi}
        tbl[0]  = row(1'b0, 8'hAA, 5'b00000);
        tbl[1]  = row(1'b1, 8'h55, 5'b00000);
        tbl[2]  = row(1'b0, 8'h1B, 5'b01000);
        tbl[3]  = row(1'b1, 8'h40, 5'b01000);
        tbl[4]  = row(1'b1, 8'h0A, 5'b11110);
        tbl[5]  = row(1'b0, 8'h20, 5'b11111);
        tbl[6]  = row(1'b0, 8'h08, 5'b11110);
        tbl[7]  = row(1'b1, 8'hFF, 5'b11110);
        tbl[8]  = row(1'b0, 8'h12, 5'b00000);
        tbl[9]  = row(1'b1, 8'h88, 5'b10000);
        tbl[10] = row(1'b0, 8'h11, 5'b00000);
        tbl[11] = row(1'b1, 8'h20, 5'b00000);
        tbl[12] = row(1'b1, 8'h05, 5'b00000);
        tbl[13] = row(1'b1, 8'h02, 5'b10010);
        tbl[14] = row(1'b0, 8'h20, 5'b10011);
        tbl[15] = row(1'b0, 8'h18, 5'b01000);
        tbl[16] = row(1'b0, 8'h00, 5'b01000);
        tbl[17] = row(1'b1, 8'hF8, 5'b01000);
        tbl[18] = row(1'b1, 8'h00, 5'b11000);
        tbl[19] = row(1'b0, 8'h28, 5'b11000);

        m_init = 0; m_ltim = 0; m_sngl = 0; m_buff = 0;
        m_ar = 0; m_eoi = 0; m_base = 0; m_icw3 = 0;

        reset = 1'b1;
        bus.a0 = 1'b0; bus.wrflg = 1'b0; bus.rdflag = 1'b0;
        bus.rwadr = 3'd0; bus.inta = 1'b0;
        tb_oe = 1'b0; tb_dat = 8'h00;
        R = 0; Y = 0; isprior = 0; S = 0; CLsig = 0;
        Mask = 0; isr = 0; irr = 0;

        // Reset with active-looking inputs
        bus.inta = 1'b1; bus.wrflg = 1'b1; bus.a0 = 1'b0;
        tb_oe = 1'b1; tb_dat = 8'hAA; S = 1'b1; isr = 8'hAA;
        tick();
        tick();
        chk("rst int", bus.int_o, 1'b0);
        chk("rst ino", ino, 1'b0);
        chk("rst en", bus.en, 1'b0);
        chk("rst buff", buff, 1'b0);
        chk("rst ltim", LTIM, 1'b0);
        chk("rst eoi", eoi, 1'b0);
        chk("rst ar", ar, 1'b0);
        bus.inta = 1'b0; bus.wrflg = 1'b0; tb_oe = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Vector table
        for (int i = 0; i < 20; i++) begin
            wr(tbl[i].a0, tbl[i].d);
            chk($sformatf("tbl%0d ino", i), ino, tbl[i].exp[4]);
            chk($sformatf("tbl%0d ltim", i), LTIM, tbl[i].exp[3]);
            chk($sformatf("tbl%0d buff", i), buff, tbl[i].exp[2]);
            chk($sformatf("tbl%0d ar", i), ar, tbl[i].exp[1]);
            chk($sformatf("tbl%0d eoi", i), eoi, tbl[i].exp[0]);
        end

        // EOI command is a single-cycle pulse
        wr(1'b0, 8'h20);
        chk("eoi cmd", eoi, 1'b1);
        tick();
        chk("eoi cmd end", eoi, 1'b0);

        // Single mode, AEOI, IR2 at base 0x40
        wr(1'b0, 8'h13); wr(1'b1, 8'h40); wr(1'b1, 8'h02);
        check_modes("sngl init");
        R = 8'h04; Y = 3'd2; isprior = 1'b1;
        tick();
        chk("sngl int", bus.int_o, 1'b1);
        isprior = 1'b0; R = 8'h00;
        inta_seq("sngl", 1'b1, 8'h42, 1'b1);

        // Reads
        bus.rdflag = 1'b1; bus.rwadr = 3'd1; isr = 8'h81;
        #1;
        chk("rd isr en", bus.en, 1'b1);
        chk("rd isr", D, 8'h81);
        bus.rwadr = 3'd5;
        #1;
        chk("rd none", D, 8'h00);
        bus.inta = 1'b1;
        #1;
        chk("rd inta prec", bus.en, 1'b0);
        bus.inta = 1'b0; bus.rdflag = 1'b0;
        #1;
        chk("rd off en", bus.en, 1'b0);
        tick();

        // Slave in cascade
        wr(1'b0, 8'h11); wr(1'b1, 8'h80); wr(1'b1, 8'h03); wr(1'b1, 8'h00);
        check_modes("slave init");
        S = 1'b0; CLsig = 1'b0; Y = 3'd5;
        inta_seq("slave nocl", 1'b0, 8'h85, 1'b0);
        CLsig = 1'b1;
        inta_seq("slave cl", 1'b1, 8'h85, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 4);
            if (op == 0) begin
                wr(1'b0, 8'($urandom) | 8'h10);
                check_modes("rnd icw1");
                for (int k = 0; k < 3 && m_need.size() > 0; k++) begin
                    wr(1'b1, 8'($urandom));
                    check_modes("rnd icw");
                end
            end else if (op == 1) begin
                wr(1'($urandom), 8'($urandom));
                check_modes("rnd wr");
            end else if (op == 2) begin
                irr = 8'($urandom); isr = 8'($urandom); Mask = 8'($urandom);
                ra = 3'($urandom);
                case (ra)
                    3'd0:    ev = irr;
                    3'd1:    ev = isr;
                    3'd2:    ev = Mask;
                    default: ev = 8'h00;
                endcase
                bus.rwadr = ra; bus.rdflag = 1'b1;
                #1;
                chk("rnd rd en", bus.en, 1'b1);
                chk("rnd rd", D, ev);
                bus.rdflag = 1'b0;
                #1;
                chk("rnd rd off", bus.en, 1'b0);
            end else if (op == 3) begin
                if (m_ready()) begin
                    d = (8'($urandom) & 8'hC7) | 8'h20;
                    wr(1'b0, d);
                    check_modes("rnd eoi");
                    tick();
                    chk("rnd eoi end", eoi, 1'b0);
                end
            end else begin
                y = 3'($urandom);
                S = 1'($urandom); CLsig = 1'($urandom);
                R = 8'h01 << y; Y = y; isprior = 1'b1;
                tick();
                chk("rnd int", bus.int_o, m_ready());
                isprior = 1'b0; R = 8'h00;
                if (m_ready()) begin
                    drv = m_sngl || (S ? ((m_icw3 >> y) & 8'h01) == 0 : CLsig);
                    inta_seq("rnd inta", drv, m_base + 8'(y), m_ar);
                end else begin
                    tick();
                    chk("rnd noint", bus.int_o, 1'b0);
                end
            end
        end

        // Reset in the middle of vector drive
        wr(1'b0, 8'h13); wr(1'b1, 8'h40); wr(1'b1, 8'h00);
        Y = 3'd3;
        bus.inta = 1'b1; tick(); bus.inta = 1'b0; tick();
        bus.inta = 1'b1; tick();
        chk("midrst en before", bus.en, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst en", bus.en, 1'b0);
        chk("midrst ino", ino, 1'b0);
        tick();
        bus.inta = 1'b0;
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
